i2s_adc_receiver: RTL

Captures stereo 16-bit audio from the Pmod I2S2 A/D side and holds the most recent left/right samples for the rest of the game logic.
It acts as I2S bus master on the ADC connector and generates MCLK, LRCK and SCK with the same ratios as the DAC side, so both converters run at one sample rate.
It also drives a 5-LED peak-level bar with timed decay, for an input-level indicator next to the volume LEDs.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_adc_receiver_if.sv | 24 ++
 rtl/i2s_adc_receiver_peak_meter.sv | 55 +++++
 rtl/i2s_adc_receiver.sv | 88 ++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S divider taps, capture phase and widths for the ADC and DAC sides.
package i2s_pkg;

  localparam int unsigned CNT_W    = 9;
  localparam int unsigned MCLK_BIT = 1;
  localparam int unsigned SCK_BIT  = 3;
  localparam int unsigned LRCK_BIT = 8;
  localparam int unsigned CE_PHASE = 11;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned LED_W    = 5;

  // |s| clamped so that the most negative code maps to full scale.
  function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = -s;
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      return '1;
    end
    return s[SAMPLE_W-1] ? neg[SAMPLE_W-2:0] : s[SAMPLE_W-2:0];
  endfunction

endpackage

// File: rtl/i2s_adc_receiver_if.sv
// ADC-side I2S pins plus the captured-sample and level-bar outputs.
interface i2s_adc_receiver_if;
  import i2s_pkg::*;

  logic                adc_sdout;
  logic                adc_mclk;
  logic                adc_lrck;
  logic                adc_sck;
  logic [SAMPLE_W-1:0] sample_left;
  logic [SAMPLE_W-1:0] sample_right;
  logic                valid;
  logic [LED_W-1:0]    level;

  modport master (
    input  adc_sdout,
    output adc_mclk, adc_lrck, adc_sck, sample_left, sample_right, valid, level
  );

  modport slave (
    output adc_sdout,
    input  adc_mclk, adc_lrck, adc_sck, sample_left, sample_right, valid, level
  );

endinterface

// File: rtl/i2s_adc_receiver_peak_meter.sv
// Held-peak level bar: peak of max(|L|,|R|) halved every DECAY_FRAMES frames.
module peak_meter
  import i2s_pkg::*;
#(
  parameter int unsigned DECAY_FRAMES = 4096,
  parameter int unsigned THR_BASE     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_sample_left,
  input  logic [SAMPLE_W-1:0] i_sample_right,
  output logic [LED_W-1:0]    o_level
);

  localparam int unsigned DecW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [DecW-1:0]     r_decay;
  logic [SAMPLE_W-2:0] r_peak;
  logic [LED_W-1:0]    r_level;
  logic [SAMPLE_W-2:0] w_mag_l, w_mag_r, w_mag, w_peak_dec, w_peak_next;
  logic                w_wrap;
  logic [LED_W-1:0]    w_level;

  always_comb begin
    w_mag_l     = abs_sat(i_sample_left);
    w_mag_r     = abs_sat(i_sample_right);
    w_mag       = (w_mag_l > w_mag_r) ? w_mag_l : w_mag_r;
    w_wrap      = (r_decay == DecW'(DECAY_FRAMES - 1));
    w_peak_dec  = w_wrap ? (r_peak >> 1) : r_peak;
    // A fresh sample larger than the decayed peak wins in the decay frame.
    w_peak_next = (w_mag > w_peak_dec) ? w_mag : w_peak_dec;
    w_level     = '0;
    for (int i = 0; i < int'(LED_W); i++) begin
      w_level[i] = (32'(r_peak) >= (THR_BASE << i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_decay <= '0;
      r_peak  <= '0;
      r_level <= '0;
    end else begin
      if (i_valid) begin
        r_decay <= w_wrap ? '0 : r_decay + 1'b1;
        r_peak  <= w_peak_next;
      end
      r_level <= w_level;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S master for the ADC: divides clk into MCLK/SCK/LRCK and deserialises L/R words.
module i2s_adc_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned DECAY_FRAMES = 4096,
  parameter int unsigned THR_BASE     = 1024
) (
  input  logic               clk,
  input  logic               rst,
  i2s_adc_receiver_if.master bus
);

  logic [CNT_W-1:0]    r_cnt;
  logic                r_mclk, r_sck, r_lrck;
  logic                r_sd_meta, r_sd_s;
  logic [SAMPLE_W-2:0] r_shift;
  logic [SAMPLE_W-1:0] r_pending_left, r_sample_left, r_sample_right;
  logic                r_first_done;
  logic                r_valid;

  logic                w_ce;
  logic [3:0]          w_slot;
  logic [SAMPLE_W-1:0] w_word;
  logic [LED_W-1:0]    w_level;

  assign w_ce   = (r_cnt[3:0] == 4'(CE_PHASE));
  assign w_slot = r_cnt[7:4];
  assign w_word = {r_shift, r_sd_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_mclk         <= 1'b0;
      r_sck          <= 1'b0;
      r_lrck         <= 1'b0;
      r_sd_meta      <= 1'b0;
      r_sd_s         <= 1'b0;
      r_shift        <= '0;
      r_pending_left <= '0;
      r_sample_left  <= '0;
      r_sample_right <= '0;
      r_first_done   <= 1'b0;
      r_valid        <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
      r_mclk    <= r_cnt[MCLK_BIT];
      r_sck     <= r_cnt[SCK_BIT];
      r_lrck    <= r_cnt[LRCK_BIT];
      r_sd_meta <= bus.adc_sdout;
      r_sd_s    <= r_sd_meta;
      r_valid   <= 1'b0;
      if (w_ce) begin
        if (w_slot != 4'd0) begin
          r_shift <= w_word[SAMPLE_W-2:0];
        end else if (r_cnt[LRCK_BIT]) begin
          // Slot 0 of the right half carries the left LSB (one-bit I2S delay).
          r_pending_left <= w_word;
          r_first_done   <= 1'b1;
        end else if (r_first_done) begin
          r_sample_left  <= r_pending_left;
          r_sample_right <= w_word;
          r_valid        <= 1'b1;
        end
      end
    end
  end

  peak_meter #(
    .DECAY_FRAMES (DECAY_FRAMES),
    .THR_BASE     (THR_BASE)
  ) u_peak_meter (
    .clk            (clk),
    .rst            (rst),
    .i_valid        (r_valid),
    .i_sample_left  (r_sample_left),
    .i_sample_right (r_sample_right),
    .o_level        (w_level)
  );

  assign bus.adc_mclk     = r_mclk;
  assign bus.adc_sck      = r_sck;
  assign bus.adc_lrck     = r_lrck;
  assign bus.sample_left  = r_sample_left;
  assign bus.sample_right = r_sample_right;
  assign bus.valid        = r_valid;
  assign bus.level        = w_level;

endmodule
